// File: rtl/div_seq_pkg.sv
// Shared state encodings and sizing for the iterative divider sequencer.
package div_seq_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;
    localparam int DIV_ST_W  = 2;

    typedef enum logic [DIV_ST_W-1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_FIX  = 2'd2,
        DIV_ST_DONE = 2'd3
    } div_st_e;
endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage and the divider sequencer.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed_op;
    logic [WIDTH-1:0] i_opr1;
    logic [WIDTH-1:0] i_opr2;
    logic             i_flush;
    logic             i_ack;
    logic             o_stall_req;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quot;
    logic [WIDTH-1:0] o_rem;

    modport master (
        output i_start, i_signed_op, i_opr1, i_opr2, i_flush, i_ack,
        input  o_stall_req, o_busy, o_done, o_quot, o_rem
    );

    modport slave (
        input  i_start, i_signed_op, i_opr1, i_opr2, i_flush, i_ack,
        output o_stall_req, o_busy, o_done, o_quot, o_rem
    );
endinterface

// File: rtl/div_seq_step.sv
// One combinational restoring-division step; the shifted partial remainder is kept
// one bit wider so divisors with the MSB set do not lose the carried-out bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem_part,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH-1:0] o_rem_part,
    output logic             o_qbit
);
    logic [WIDTH:0] w_p;
    logic [WIDTH:0] w_dvsr_ext;

    assign w_p        = {i_rem_part, i_dvd_msb};
    assign w_dvsr_ext = {1'b0, i_dvsr};
    assign o_qbit     = (w_p >= w_dvsr_ext);
    assign o_rem_part = WIDTH'(o_qbit ? (w_p - w_dvsr_ext) : w_p);
endmodule

// File: rtl/div_seq.sv
// Iterative restoring DIV/DIVU: 34 cycles start->done (1 for divide-by-zero), stalls EX while in flight,
// holds the result in DONE until ack; flush returns to IDLE from any state.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

    div_st_e          r_state;
    div_st_e          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_rem_part;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_qbit;

    assign w_accept = (r_state == DIV_ST_IDLE) && bus.i_start && !bus.i_flush;
    assign w_s1     = bus.i_signed_op && bus.i_opr1[WIDTH-1];
    assign w_s2     = bus.i_signed_op && bus.i_opr2[WIDTH-1];
    assign w_abs1   = w_s1 ? (~bus.i_opr1 + 1'b1) : bus.i_opr1;
    assign w_abs2   = w_s2 ? (~bus.i_opr2 + 1'b1) : bus.i_opr2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem_part (r_rem_part),
        .i_dvd_msb  (r_dvd[WIDTH-1]),
        .i_dvsr     (r_dvsr),
        .o_rem_part (w_step_rem),
        .o_qbit     (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.i_opr2 == '0) ? DIV_ST_DONE : DIV_ST_BUSY;
                end
            end
            DIV_ST_BUSY: begin
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = DIV_ST_FIX;
                end
            end
            DIV_ST_FIX:  w_state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: begin
                if (bus.i_ack) begin
                    w_state_nxt = DIV_ST_IDLE;
                end
            end
            default:     w_state_nxt = DIV_ST_IDLE;
        endcase
        if (bus.i_flush) begin
            w_state_nxt = DIV_ST_IDLE;
        end
    end

    // r_dvd doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dvsr     <= '0;
            r_rem_part <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != DIV_ST_IDLE);
            r_done <= (w_state_nxt == DIV_ST_DONE);
            case (r_state)
                DIV_ST_IDLE: begin
                    if (w_accept) begin
                        r_dvd      <= w_abs1;
                        r_dvsr     <= w_abs2;
                        r_rem_part <= '0;
                        r_cnt      <= '0;
                        r_q_neg    <= w_s1 ^ w_s2;
                        r_r_neg    <= w_s1;
                        if (bus.i_opr2 == '0) begin
                            r_quot <= '1;
                            r_rem  <= bus.i_opr1;
                        end
                    end
                end
                DIV_ST_BUSY: begin
                    if (!bus.i_flush) begin
                        r_rem_part <= w_step_rem;
                        r_dvd      <= {r_dvd[WIDTH-2:0], w_qbit};
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                DIV_ST_FIX: begin
                    if (!bus.i_flush) begin
                        r_quot <= r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
                        r_rem  <= r_r_neg ? (~r_rem_part + 1'b1) : r_rem_part;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_stall_req = w_accept || (r_state == DIV_ST_BUSY) || (r_state == DIV_ST_FIX);
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_quot      = r_quot;
    assign bus.o_rem       = r_rem;
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq timing, results, flush, hold and async reset.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(32)) bus();
    div_seq #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] last_q = 32'h0;
    logic [31:0] last_r = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat, input int ack_dly);
        int n;
        int stalls;
        bus.i_signed_op = sgn;
        bus.i_opr1      = a;
        bus.i_opr2      = b;
        bus.i_start     = 1'b1;
        #1 chk({tag, ":stall_T"}, 32'(bus.o_stall_req), 32'd1);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_opr1  = ~a;
        bus.i_opr2  = ~b;
        n = 0;
        stalls = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.o_done) break;
            if (bus.o_stall_req) stalls++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(elat));
        chk({tag, ":stall_cycles"}, 32'(stalls), 32'(elat - 1));
        chk({tag, ":stall_done"}, 32'(bus.o_stall_req), 32'd0);
        chk({tag, ":quot"}, bus.o_quot, eq);
        chk({tag, ":rem"}, bus.o_rem, er);
        for (int i = 0; i < ack_dly; i++) begin
            bus.i_start = 1'($urandom_range(0, 1));
            bus.i_opr1  = $urandom;
            bus.i_opr2  = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk({tag, ":hold_done"}, 32'(bus.o_done), 32'd1);
            chk({tag, ":hold_quot"}, bus.o_quot, eq);
            chk({tag, ":hold_rem"}, bus.o_rem, er);
        end
        bus.i_start = 1'b0;
        bus.i_ack   = 1'b1;
        @(posedge clk);
        #1 bus.i_ack = 1'b0;
        @(negedge clk);
        chk({tag, ":ack_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, ":ack_done"}, 32'(bus.o_done), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    // Start an op, then flush (with a competing start) during cycle T+k.
    task automatic flush_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input int k);
        bit seen_done;
        seen_done = 1'b0;
        bus.i_signed_op = sgn;
        bus.i_opr1      = a;
        bus.i_opr2      = b;
        bus.i_start     = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        for (int n = 1; n <= k; n++) begin
            @(negedge clk);
            if (bus.o_done) seen_done = 1'b1;
        end
        bus.i_flush = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk({tag, ":no_done"}, 32'(seen_done | bus.o_done), 32'd0);
        chk({tag, ":busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, ":quot_kept"}, bus.o_quot, last_q);
        chk({tag, ":rem_kept"}, bus.o_rem, last_r);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sgn;
        logic [31:0] a, b, eq, er;

        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_signed_op = 1'b0; bus.i_flush = 1'b0; bus.i_ack = 1'b0;
        bus.i_opr1 = 32'h0; bus.i_opr2 = 32'h0;
        #1;
        chk("reset:busy", 32'(bus.o_busy), 32'd0);
        chk("reset:done", 32'(bus.o_done), 32'd0);
        chk("reset:quot", bus.o_quot, 32'd0);
        chk("reset:rem", bus.o_rem, 32'd0);
        chk("reset:stall", 32'(bus.o_stall_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 1);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 0);
        run_op("divu_by0", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 0);
        run_op("div_by0_neg", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1, 0);
        run_op("divu_bigdvsr", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 34, 0);

        flush_op("flush_t10", 1'b0, 32'd50, 32'd5, 10);
        run_op("after_flush", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 34, 0);

        run_op("hold_ack", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 5);

        bus.i_opr1 = 32'd100; bus.i_opr2 = 32'd7; bus.i_signed_op = 1'b0; bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid:quot", bus.o_quot, 32'd0);
        chk("rst_mid:rem", bus.o_rem, 32'd0);
        chk("rst_mid:busy", 32'(bus.o_busy), 32'd0);
        chk("rst_mid:done", 32'(bus.o_done), 32'd0);
        chk("rst_mid:stall", 32'(bus.o_stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_q = 32'h0;
        last_r = 32'h0;
        @(negedge clk);

        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 0);

        for (int i = 0; i < 300; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(sgn, a, b, eq, er);
            if ((b != 32'h0) && ($urandom_range(0, 7) == 0)) begin
                flush_op("rnd_flush", sgn, a, b, $urandom_range(1, 30));
            end else begin
                run_op("rnd", sgn, a, b, eq, er, (b == 32'h0) ? 1 : 34, $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
